// File: rtl/gci_device_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gci_device_pkg
// Description : Shared definitions for the GCI device responder: FSM state
//               encoding, doorbell field positions and bus RW encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package gci_device_pkg;

    typedef enum logic [2:0] {
        INIT_WAIT = 3'd0,
        INIT_SEND = 3'd1,
        IDLE      = 3'd2,
        READ_WAIT = 3'd3,
        READ_RESP = 3'd4
    } state_t;

    // Doorbell word layout: bit 6 arms the interrupt, bits [5:0] carry its number.
    localparam int DOORBELL_EN_BIT  = 6;
    localparam int DOORBELL_NUM_MSB = 5;
    localparam int DOORBELL_NUM_LSB = 0;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage : gci_device_pkg
`default_nettype wire

// File: rtl/gci_device_ram.sv
`default_nettype none
// ============================================================================
// Module      : gci_device_ram
// Description : Single-port word RAM, 2**P_DEPTH_LOG2 x 32, synchronous read.
//               Contents and read register are not reset.
// Ports       : clk   - clock
//               en    - port enable (read or write this cycle)
//               we    - write enable (qualified by en)
//               addr  - word index
//               wdata - write data
//               rdata - read data, valid the cycle after an enabled read;
//                       holds until the next enabled read
// Revision    : 1.0 - initial release
// ============================================================================
module gci_device_ram #(
    parameter int P_DEPTH_LOG2 = 8
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [P_DEPTH_LOG2-1:0] addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata
);

    logic [31:0] mem [2**P_DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule : gci_device_ram
`default_nettype wire

// File: rtl/gci_device_responder.sv
`default_nettype none
// ============================================================================
// Module      : gci_device_responder
// Description : Responder end of the core's GCI bus. After reset it announces
//               its size word, then serves single-outstanding word reads and
//               writes into a local RAM. A write to the doorbell address raises
//               an interrupt held until acknowledged.
// Options     : GCI_DEVICE_READ_DELAY_EN - stretch READ_WAIT by P_READ_DELAY
//               cycles to model a slow device.
// Ports       : iCLOCK, iRESET_SYNC      - clock, synchronous active-high reset
//               iGCI_REQ/RW/ADDR/DATA    - request from the core
//               oGCI_BUSY                - device cannot accept a request
//               oGCI_REQ/oGCI_DATA       - response / announcement beat
//               iGCI_BUSY                - core cannot take a response
//               oGCI_IRQ_REQ/NUM         - interrupt request and number
//               iGCI_IRQ_ACK             - interrupt acknowledge
// Revision    : 1.0 - initial release
// ============================================================================
module gci_device_responder
    import gci_device_pkg::*;
#(
    parameter logic [31:0] P_GCI_SIZE   = 32'h0001_0000,
    parameter int          P_INIT_DELAY = 32,
    parameter int          P_DEPTH_LOG2 = 8,
    parameter logic [31:0] P_IRQ_ADDR   = 32'h0000_FFFC,
    parameter int          P_READ_DELAY = 4
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iGCI_REQ,
    output logic        oGCI_BUSY,
    input  logic        iGCI_RW,
    input  logic [31:0] iGCI_ADDR,
    input  logic [31:0] iGCI_DATA,
    output logic        oGCI_REQ,
    input  logic        iGCI_BUSY,
    output logic [31:0] oGCI_DATA,
    output logic        oGCI_IRQ_REQ,
    output logic [5:0]  oGCI_IRQ_NUM,
    input  logic        iGCI_IRQ_ACK
);

`ifdef GCI_DEVICE_READ_DELAY_EN
    localparam int EXTRA_WAIT = P_READ_DELAY;
`else
    localparam int EXTRA_WAIT = P_READ_DELAY * 0;
`endif

    // First byte address past the RAM; 33 bits so large depths cannot wrap.
    localparam logic [32:0] RANGE_LIMIT = 33'd4 << P_DEPTH_LOG2;

    state_t      state;
    state_t      state_next;
    logic [31:0] init_cnt;
    logic [31:0] wait_cnt;
    logic        busy_q;
    logic        req_q;
    logic        req_next;
    logic [31:0] data_q;
    logic [31:0] data_next;
    logic        read_zero_q;
    logic        irq_req_q;
    logic [5:0]  irq_num_q;

    logic        is_irq_addr;
    logic        out_of_range;
    logic        is_write;
    logic        accept;
    logic        ram_en;
    logic        ram_we;
    logic        doorbell;
    logic [31:0] ram_rdata;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    assign is_irq_addr  = (iGCI_ADDR[31:2] == P_IRQ_ADDR[31:2]);
    assign out_of_range = ({1'b0, iGCI_ADDR} >= RANGE_LIMIT);
    assign is_write     = (iGCI_RW == RW_WRITE);
    assign accept       = (state == IDLE) && iGCI_REQ && !iRESET_SYNC;
    assign ram_we       = accept && is_write && !is_irq_addr && !out_of_range;
    // Reads always touch the RAM; out-of-range/doorbell reads are zeroed later.
    assign ram_en       = ram_we || (accept && !is_write);
    assign doorbell     = accept && is_write && is_irq_addr;

    gci_device_ram #(
        .P_DEPTH_LOG2 (P_DEPTH_LOG2)
    ) u_ram (
        .clk   (iCLOCK),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (iGCI_ADDR[P_DEPTH_LOG2+1:2]),
        .wdata (iGCI_DATA),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------------
    // Bus FSM: next state and next response beat
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req_next   = req_q;
        data_next  = data_q;
        case (state)
            INIT_WAIT: begin
                req_next  = 1'b0;
                data_next = 32'h0;
                if (init_cnt == 32'(P_INIT_DELAY - 1)) begin
                    state_next = INIT_SEND;
                end
            end
            INIT_SEND: begin
                if (!iGCI_BUSY) begin
                    req_next   = 1'b1;
                    data_next  = P_GCI_SIZE;
                    state_next = IDLE;
                end
            end
            IDLE: begin
                req_next  = 1'b0;
                data_next = 32'h0;
                if (accept && !is_write) begin
                    state_next = READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (wait_cnt == 32'(EXTRA_WAIT)) begin
                    req_next   = 1'b1;
                    data_next  = read_zero_q ? 32'h0 : ram_rdata;
                    state_next = READ_RESP;
                end
            end
            READ_RESP: begin
                // Beat held stable until the core can take it.
                if (!iGCI_BUSY) begin
                    req_next   = 1'b0;
                    data_next  = 32'h0;
                    state_next = IDLE;
                end
            end
            default: begin
                req_next   = 1'b0;
                data_next  = 32'h0;
                state_next = INIT_WAIT;
            end
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state       <= INIT_WAIT;
            init_cnt    <= 32'h0;
            wait_cnt    <= 32'h0;
            busy_q      <= 1'b1;
            req_q       <= 1'b0;
            data_q      <= 32'h0;
            read_zero_q <= 1'b0;
        end else begin
            state    <= state_next;
            req_q    <= req_next;
            data_q   <= data_next;
            // Busy is a registered copy of the current state, so it lags the
            // state by one cycle and stays high through the announcement beat.
            busy_q   <= (state != IDLE);
            init_cnt <= (state == INIT_WAIT) ? init_cnt + 32'h1 : 32'h0;
            wait_cnt <= (state == READ_WAIT) ? wait_cnt + 32'h1 : 32'h0;
            if (accept && !is_write) begin
                read_zero_q <= out_of_range || is_irq_addr;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Interrupt: independent of the bus FSM. A pending IRQ blocks new
    // doorbells, which also makes ACK win over a same-cycle doorbell.
    // ------------------------------------------------------------------------
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            irq_req_q <= 1'b0;
            irq_num_q <= 6'h0;
        end else if (irq_req_q) begin
            if (iGCI_IRQ_ACK) begin
                irq_req_q <= 1'b0;
            end
        end else if (doorbell && iGCI_DATA[DOORBELL_EN_BIT]) begin
            irq_req_q <= 1'b1;
            irq_num_q <= iGCI_DATA[DOORBELL_NUM_MSB:DOORBELL_NUM_LSB];
        end
    end

    assign oGCI_BUSY    = busy_q;
    assign oGCI_REQ     = req_q;
    assign oGCI_DATA    = data_q;
    assign oGCI_IRQ_REQ = irq_req_q;
    assign oGCI_IRQ_NUM = irq_num_q;

endmodule : gci_device_responder
`default_nettype wire
